uart_ctrl: RTL and testbench
============================

# uart_ctrl

Memory-mapped UART controller for the pipelined MIPS CPU. It sequences the serial transmitter and receiver, buffers one received byte, and exposes data and status registers on the CPU peripheral bus. It raises an interrupt request on transmit-complete or receive-valid. It sits beside the LED/digit peripherals in the CPU's peripheral address space and drives the board pins UART_TX and UART_RX.

## Interface
- CLKS_PER_BIT, 10416: sysclk cycles per serial bit; 9600 baud at 100 MHz. Must be even and ≥ 4.
- sysclk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- addr  in  8  byte offset within the peripheral page: 0x18 TXD, 0x1C RXD, 0x20 CON.
- rd  in  1  read strobe; its side effects take place at the clock edge.
- wr  in  1  write strobe.
- wdata  in  32  write data.
- rdata  out  32  combinational read data; 0 for unmapped offsets or when rd=0.
- irq  out  1  interrupt request, level.
- UART_RX  in  1  serial input; idle high.
- UART_TX  out  1  serial output, registered; idle high.

## Operation
- UART_RX passes through a 2-flop synchronizer. Both flops reset to 1.
- TXD write (wr, addr 0x18) with tx_busy=0:
  - Latch wdata[7:0].
  - Set tx_busy.
  - Start the frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- A TXD write while tx_busy=1 is dropped. It has no effect on any state.
- TX FSM states: IDLE → START → DATA (bit index 0..7) → STOP → IDLE. Each state lasts CLKS_PER_BIT cycles.
- Leaving STOP clears tx_busy and sets the sticky tx_done bit.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE→START: synchronized RX = 0.
  - At CLKS_PER_BIT/2 into START, RX is sampled. If it reads 1, this is a false start: return to IDLE.
  - Data bits are sampled every CLKS_PER_BIT after that point.
  - The stop bit is sampled at 9.5·CLKS_PER_BIT from the detected falling edge.
- Stop sample = 1: load rx_data and set rx_valid. If rx_valid was already 1, also set overrun; the new byte overwrites the old one.
- Stop sample = 0: set frame_err and discard the byte.
- RXD read returns {24'b0, rx_data} and clears rx_valid.
- CON register:
  - Bit 0: tx_irq_en (R/W).
  - Bit 1: rx_irq_en (R/W).
  - Bit 2: tx_done.
  - Bit 3: rx_valid.
  - Bit 4: tx_busy.
  - Bit 5: overrun.
  - Bit 6: frame_err.
  - Bits 31:7 read 0.
  - A CON write updates only bits 1:0.
  - A CON read clears tx_done, overrun and frame_err.
- TXD reads as {24'b0, last byte written}.
- irq = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid).

## Timing
- Reset values: UART_TX=1, irq=0, every CON bit 0, rx_data=0, TX byte 0, both FSMs IDLE.
- Reset mid-frame aborts the frame. UART_TX returns to 1 on the next edge.
- Write accepted at edge k: UART_TX=0 from edge k+1.
  - Data bit n is driven from k+1+(n+1)·CLKS_PER_BIT.
  - Stop bit is driven from k+1+9·CLKS_PER_BIT.
  - tx_busy=0 and tx_done=1 from k+1+10·CLKS_PER_BIT.
- A write at the same edge where tx_busy falls is dropped, because tx_busy is still 1 at that edge. Software polls tx_busy before writing.
- RX latency: rx_valid rises 9.5·CLKS_PER_BIT + 2 cycles after the RX falling edge. The +2 is synchronizer delay.
- RXD read at the same edge as a new byte completes: the new byte wins. rx_valid stays 1 and overrun is not set.
- CON read at the same edge as a flag being set: the set wins, and the flag reads 1 afterwards.
- irq follows the flags combinationally, with no added delay.

## Test plan
Sim with CLKS_PER_BIT=16 unless noted.
- Reset, then write TXD=0x55 → UART_TX low for 16 cycles, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high. tx_done=1 exactly 161 cycles after the write edge. CON read returns 0x04, and a second read returns 0x00.
- Drive the RX frame for 0xA3 with a valid stop bit → rx_valid=1 at 154 cycles after the falling edge. RXD read returns 0x000000A3. A following CON read shows bit 3 = 0.
- Send 0x11 then 0x22 without reading → overrun=1. RXD reads 0x22.
- Drive a start bit of only 4 cycles → no rx_valid, no frame_err, RX FSM back in IDLE.
- Drive a frame with the stop bit held 0 → frame_err=1, rx_valid=0. With rx_irq_en=1, irq stays 0.
- Write CON=0x1, write TXD=0x0F, then write TXD=0xF0 at cycle 50 → the 0xF0 write is dropped and only the 0x0F frame is sent. irq rises at frame end and falls after a CON read. Reset asserted mid-frame in a repeat run → UART_TX=1 and CON=0 on the next edge.

Source files
------------

// File: rtl/uart_ctrl_if.sv
// Peripheral-bus view of the UART controller: register strobes, read data and interrupt line.
interface uart_ctrl_if;
  logic [7:0]  addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, rd, wr, wdata, input rdata, irq);
  modport slave  (input addr, rd, wr, wdata, output rdata, irq);
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped 8N1 UART: TX/RX sequencers, one-byte receive buffer, TXD/RXD/CON registers and irq.
module uart_ctrl #(
  parameter int CLKS_PER_BIT = 10416
) (
  input  logic        sysclk,
  input  logic        reset,
  uart_ctrl_if.slave  bus,
  input  logic        UART_RX,
  output logic        UART_TX
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] ADDR_TXD = 8'h18;
  localparam logic [7:0] ADDR_RXD = 8'h1C;
  localparam logic [7:0] ADDR_CON = 8'h20;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  uart_state_e   tx_state, tx_state_n, rx_state, rx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n, rx_idx, rx_idx_n;
  logic          tx_q, tx_n, tx_finish;
  logic [7:0]    tx_byte, rx_shift, rx_data;
  logic          rx_meta, rx_sync, rx_shift_en, rx_good, rx_bad;
  logic          tx_irq_en, rx_irq_en, tx_done, rx_valid, tx_busy, overrun, frame_err;
  logic          txd_wr, con_wr, con_rd, rxd_rd;
  logic [31:0]   rdata;
  logic          unused_wdata;

  // Writes to TXD while a frame is in flight are silently dropped.
  assign txd_wr = bus.wr && (bus.addr == ADDR_TXD) && !tx_busy;
  assign con_wr = bus.wr && (bus.addr == ADDR_CON);
  assign con_rd = bus.rd && (bus.addr == ADDR_CON);
  assign rxd_rd = bus.rd && (bus.addr == ADDR_RXD);
  assign unused_wdata = &{1'b0, bus.wdata[31:8]};

  // The TX FSM leaves IDLE one edge after tx_busy is set, so UART_TX falls one cycle after the write.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + 1'b1;
    tx_idx_n   = tx_idx;
    tx_n       = tx_q;
    tx_finish  = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_cnt_n = '0;
        tx_n     = 1'b1;
        if (tx_busy) begin
          tx_state_n = START;
          tx_n       = 1'b0;
        end
      end
      START: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_idx_n   = '0;
        tx_state_n = DATA;
        tx_n       = tx_byte[0];
      end
      DATA: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n = '0;
        if (tx_idx == 3'd7) begin
          tx_state_n = STOP;
          tx_n       = 1'b1;
        end else begin
          tx_idx_n = tx_idx + 3'd1;
          tx_n     = tx_byte[tx_idx + 3'd1];
        end
      end
      STOP: if (tx_cnt == BIT_LAST) begin
        tx_cnt_n   = '0;
        tx_state_n = IDLE;
        tx_finish  = 1'b1;
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // RX samples mid-bit: half a bit after the detected start edge, then once per bit period.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt + 1'b1;
    rx_idx_n    = rx_idx;
    rx_shift_en = 1'b0;
    rx_good     = 1'b0;
    rx_bad      = 1'b0;
    case (rx_state)
      IDLE: begin
        rx_cnt_n = '0;
        if (!rx_sync) rx_state_n = START;
      end
      START: if (rx_cnt == HALF_LAST) begin
        rx_cnt_n   = '0;
        rx_idx_n   = '0;
        rx_state_n = rx_sync ? IDLE : DATA;
      end
      DATA: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n    = '0;
        rx_shift_en = 1'b1;
        if (rx_idx == 3'd7) rx_state_n = STOP;
        else                rx_idx_n   = rx_idx + 3'd1;
      end
      STOP: if (rx_cnt == BIT_LAST) begin
        rx_cnt_n   = '0;
        rx_state_n = IDLE;
        rx_good    = rx_sync;
        rx_bad     = !rx_sync;
      end
      default: rx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    // NOTE: all state here uses non-blocking assignments so every flop sees pre-edge values.
    if (!reset) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      tx_state  <= IDLE;
      rx_state  <= IDLE;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      tx_idx    <= '0;
      rx_idx    <= '0;
      tx_q      <= 1'b1;
      tx_byte   <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      tx_irq_en <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_done   <= 1'b0;
      rx_valid  <= 1'b0;
      tx_busy   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta  <= UART_RX;
      rx_sync  <= rx_meta;
      tx_state <= tx_state_n;
      rx_state <= rx_state_n;
      tx_cnt   <= tx_cnt_n;
      rx_cnt   <= rx_cnt_n;
      tx_idx   <= tx_idx_n;
      rx_idx   <= rx_idx_n;
      tx_q     <= tx_n;
      if (txd_wr) begin
        tx_byte <= bus.wdata[7:0];
        tx_busy <= 1'b1;
      end else if (tx_finish) begin
        tx_busy <= 1'b0;
      end
      if (con_wr) {rx_irq_en, tx_irq_en} <= bus.wdata[1:0];
      if (rx_shift_en) rx_shift <= {rx_sync, rx_shift[7:1]};
      if (rx_good) rx_data <= rx_shift;
      // Setting a flag takes priority over the read that would clear it in the same cycle.
      tx_done   <= tx_finish | (tx_done & !con_rd);
      rx_valid  <= rx_good | (rx_valid & !rxd_rd);
      overrun   <= (rx_good & rx_valid & !rxd_rd) | (overrun & !con_rd);
      frame_err <= rx_bad | (frame_err & !con_rd);
    end
  end

  always_comb begin
    rdata = '0;
    if (bus.rd) begin
      case (bus.addr)
        ADDR_TXD: rdata = {24'b0, tx_byte};
        ADDR_RXD: rdata = {24'b0, rx_data};
        ADDR_CON: rdata = {25'b0, frame_err, overrun, tx_busy, rx_valid, tx_done, rx_irq_en, tx_irq_en};
        default:  rdata = '0;
      endcase
    end
  end

  assign bus.rdata = rdata;
  assign bus.irq   = (tx_irq_en & tx_done) | (rx_irq_en & rx_valid);
  assign UART_TX   = tx_q;
endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl: directed and random traffic checked against a timing-arithmetic reference model.
module tb_uart_ctrl;
  localparam int C = 16;
  localparam logic [7:0] TXD = 8'h18, RXD = 8'h1C, CON = 8'h20;

  logic sysclk = 1'b0;
  logic reset = 1'b0;
  logic UART_RX = 1'b1;
  logic UART_TX;

  uart_ctrl_if bus();

  uart_ctrl #(.CLKS_PER_BIT(C)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus),
    .UART_RX(UART_RX),
    .UART_TX(UART_TX)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    int         t;
    logic [7:0] b;
    logic       ok;
  } rx_ev_t;

  rx_ev_t ev_q[$];
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;
  bit rx_active = 1'b0;

  // Reference state: a frame is described only by its accept edge and byte.
  int         m_k = -100000;
  logic       m_busy = 1'b0;
  logic [7:0] m_txb = '0;
  logic [1:0] m_en = '0;
  logic       m_done = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] m_rxd = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_tx();
    int d, p;
    d = cyc - m_k - 1;
    if (d < 0 || d >= 10 * C) return 1'b1;
    p = d / C;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_txb[p-1];
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!bus.rd) return '0;
    case (bus.addr)
      TXD:     return {24'b0, m_txb};
      RXD:     return {24'b0, m_rxd};
      CON:     return {25'b0, m_ferr, m_ovr, m_busy, m_valid, m_done, m_en};
      default: return '0;
    endcase
  endfunction

  task automatic model_step();
    logic con_rd, rxd_rd, accept, tx_fin, ev, ev_ok;
    logic [7:0] ev_b;
    if (!reset) begin
      m_k = -100000; m_busy = 0; m_txb = 0; m_en = 0; m_done = 0;
      m_valid = 0; m_ovr = 0; m_ferr = 0; m_rxd = 0;
      ev_q.delete();
      return;
    end
    con_rd = bus.rd && bus.addr == CON;
    rxd_rd = bus.rd && bus.addr == RXD;
    tx_fin = m_busy && (cyc == m_k + 1 + 10 * C);
    accept = bus.wr && bus.addr == TXD && !m_busy;
    ev = 1'b0; ev_ok = 1'b0; ev_b = '0;
    if (ev_q.size() > 0 && ev_q[0].t == cyc) begin
      ev = 1'b1; ev_ok = ev_q[0].ok; ev_b = ev_q[0].b;
      void'(ev_q.pop_front());
    end
    if (accept) begin
      m_busy = 1'b1; m_k = cyc; m_txb = bus.wdata[7:0];
    end else if (tx_fin) begin
      m_busy = 1'b0;
    end
    if (bus.wr && bus.addr == CON) m_en = bus.wdata[1:0];
    m_done = tx_fin | (m_done & ~con_rd);
    m_ovr  = (ev & ev_ok & m_valid & ~rxd_rd) | (m_ovr & ~con_rd);
    m_ferr = (ev & ~ev_ok) | (m_ferr & ~con_rd);
    m_valid = (ev & ev_ok) | (m_valid & ~rxd_rd);
    if (ev && ev_ok) m_rxd = ev_b;
  endtask

  always @(posedge sysclk) begin
    cyc++;
    model_step();
  end

  always @(negedge sysclk) begin
    if (cmp_en) begin
      check("uart_tx", {31'b0, UART_TX}, {31'b0, exp_tx()});
      check("irq", {31'b0, bus.irq}, {31'b0, (m_en[0] & m_done) | (m_en[1] & m_valid)});
      check("rdata", bus.rdata, exp_rdata());
    end
  end

  task automatic wait_until(input int e);
    while (cyc < e) begin
      @(posedge sysclk); #1;
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, output int edge_no);
    bus.addr = a; bus.wdata = d; bus.wr = 1'b1;
    @(posedge sysclk); #1;
    edge_no = cyc;
    bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    bus.addr = a; bus.rd = 1'b1;
    #1 d = bus.rdata;
    @(posedge sysclk); #1;
    bus.rd = 1'b0;
  endtask

  // Drives one serial frame; the expected completion edge is derived from the drive edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int start_len);
    logic [9:0] bits;
    rx_active = 1'b1;
    if (start_len < C) begin
      UART_RX = 1'b0;
      repeat (start_len) @(posedge sysclk);
      #1 UART_RX = 1'b1;
    end else begin
      ev_q.push_back('{t: cyc + 3 + 9 * C + C / 2, b: b, ok: stop});
      bits = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
        UART_RX = bits[i];
        repeat (C) @(posedge sysclk);
        #1;
      end
      UART_RX = 1'b1;
    end
    repeat (C) @(posedge sysclk);
    #1 rx_active = 1'b0;
  endtask

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [9:0]  pat;
    logic [7:0]  addrs [4];
    int k, k2, e, g;
    addrs[0] = TXD; addrs[1] = RXD; addrs[2] = CON; addrs[3] = 8'h24;
    bus.addr = '0; bus.rd = 1'b0; bus.wr = 1'b0; bus.wdata = '0;
    repeat (3) @(posedge sysclk);
    #1 reset = 1'b1;
    cmp_en = 1'b1;

    check("rst_uart_tx", {31'b0, UART_TX}, 32'd1);
    check("rst_irq", {31'b0, bus.irq}, 32'd0);
    bus_read(CON, d); check("rst_con", d, 32'h0);
    bus_read(RXD, d); check("rst_rxd", d, 32'h0);
    bus_read(TXD, d); check("rst_txd", d, 32'h0);

    // TX 0x55: line pattern at mid-bit points, then tx_done edge pinned via CON reads.
    bus_write(TXD, 32'h55, k);
    pat = {1'b1, 8'h55, 1'b0};
    for (int n = 0; n < 10; n++) begin
      wait_until(k + 1 + n * C + C / 2);
      check($sformatf("tx55_bit%0d", n), {31'b0, UART_TX}, {31'b0, pat[n]});
    end
    wait_until(k + 159);
    bus_read(CON, d); check("con_busy_159", d, 32'h10);
    bus_read(CON, d); check("con_busy_160", d, 32'h10);
    bus_read(CON, d); check("con_done_161", d, 32'h04);
    bus_read(CON, d); check("con_cleared", d, 32'h00);

    // RX 0xA3 with rx_irq_en: valid appears 154 cycles after the first low sample.
    bus_write(CON, 32'h2, k);
    e = cyc;
    fork send_frame(8'hA3, 1'b1, C); join_none
    wait_until(e + 154); check("rx_irq_before", {31'b0, bus.irq}, 32'd0);
    wait_until(e + 155); check("rx_irq_at_154", {31'b0, bus.irq}, 32'd1);
    bus_read(RXD, d); check("rxd_a3", d, 32'hA3);
    bus_read(CON, d); check("con_after_rxd", d, 32'h02);
    wait_until(e + 11 * C + 2);

    // Overrun: two bytes without reading.
    send_frame(8'h11, 1'b1, C);
    send_frame(8'h22, 1'b1, C);
    bus_read(CON, d); check("con_overrun", d, 32'h2A);
    bus_read(RXD, d); check("rxd_22", d, 32'h22);
    bus_read(CON, d); check("con_ovr_clr", d, 32'h02);

    // False start of 4 cycles.
    send_frame(8'h00, 1'b1, 4);
    wait_until(cyc + 2 * C);
    bus_read(CON, d); check("con_false_start", d, 32'h02);

    // Stop bit held low.
    send_frame(8'($urandom), 1'b0, C);
    check("ferr_irq", {31'b0, bus.irq}, 32'd0);
    bus_read(CON, d); check("con_frame_err", d, 32'h42);
    bus_read(CON, d); check("con_ferr_clr", d, 32'h02);

    // RXD read on the same edge a new byte lands: new byte wins, no overrun.
    send_frame(8'h5A, 1'b1, C);
    e = cyc;
    fork send_frame(8'hC6, 1'b1, C); join_none
    wait_until(e + 154);
    bus_read(RXD, d); check("rxd_old_5a", d, 32'h5A);
    bus_read(CON, d); check("con_same_edge", d, 32'h0A);
    bus_read(RXD, d); check("rxd_new_c6", d, 32'hC6);
    wait_until(e + 11 * C + 2);

    // TX irq, write while busy dropped.
    bus_write(CON, 32'h1, k);
    bus_write(TXD, 32'h0F, k);
    wait_until(k + 49);
    bus_write(TXD, 32'hF0, k2);
    check("drop_edge", k2, k + 50);
    bus_read(TXD, d); check("txd_0f", d, 32'h0F);
    wait_until(k + 160); check("tx_irq_before", {31'b0, bus.irq}, 32'd0);
    wait_until(k + 161); check("tx_irq_rise", {31'b0, bus.irq}, 32'd1);
    bus_read(CON, d); check("con_tx_irq", d, 32'h05);
    check("tx_irq_fall", {31'b0, bus.irq}, 32'd0);

    // Write on the edge where tx_busy falls is dropped.
    bus_write(TXD, 32'h3C, k);
    wait_until(k + 160);
    bus_write(TXD, 32'hC3, k2);
    bus_read(TXD, d); check("txd_3c", d, 32'h3C);
    bus_read(CON, d); check("con_edge_drop", d, 32'h05);
    wait_until(cyc + C);
    check("line_idle_after_drop", {31'b0, UART_TX}, 32'd1);

    // Reset mid-frame.
    bus_write(TXD, 32'hAA, k);
    wait_until(k + 20);
    check("aa_bit0_low", {31'b0, UART_TX}, 32'd0);
    reset = 1'b0;
    @(posedge sysclk); #1 reset = 1'b1;
    check("mid_rst_tx", {31'b0, UART_TX}, 32'd1);
    check("mid_rst_irq", {31'b0, bus.irq}, 32'd0);
    bus_read(CON, d); check("mid_rst_con", d, 32'h0);
    bus_read(TXD, d); check("mid_rst_txd", d, 32'h0);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 10; i++) begin
      bus_write(CON, $urandom, k);
      for (g = 0; g < 12 * C && m_busy; g++) begin
        @(posedge sysclk); #1;
      end
      check("tx_idle_wait", {31'b0, m_busy}, 32'd0);
      bus_write(TXD, $urandom, k);
      fork
        send_frame(8'($urandom), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, C / 2 - 1)) : C);
      join_none
      for (int j = 0; j < 6; j++) begin
        repeat ($urandom_range(0, 20)) @(posedge sysclk);
        #1;
        if ($urandom_range(0, 4) == 0) bus_write(TXD, $urandom, k2);
        else bus_read(addrs[$urandom_range(0, 3)], d);
      end
      for (g = 0; g < 20 * C && rx_active; g++) begin
        @(posedge sysclk); #1;
      end
      check("rx_drain", {31'b0, rx_active}, 32'd0);
    end

    wait_until(cyc + 12 * C);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
